path_stack_reader: RTL
======================

# path_stack_reader

Location stack and path replayer sitting on the far end of the maze-solver controller's push/pop interface. During search it stores each 8-bit cell location the controller pushes and discards it on pop, exposing top-of-stack and an empty flag. When the controller signals completion, it drains the stored path bottom-to-top, from start cell toward the destination, over a valid/ready stream to the path consumer (display or memory writer).

## Interface
Parameters:
- LOC_W, 8, location width ({x[3:0], y[3:0]})
- DEPTH, 256, stack entries (one per cell of a 16x16 maze)
- PTR_W, 9, stack-pointer width (must hold 0..DEPTH)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- push  in  1  store locIn on top of stack
- pop  in  1  discard top of stack
- locIn  in  LOC_W  location to push
- topLoc  out  LOC_W  current top entry; 0 when empty
- empStck  out  1  stack empty
- full  out  1  stack holds DEPTH entries
- done  in  1  controller finished; start replay
- pathLoc  out  LOC_W  replayed location
- pathValid  out  1  pathLoc valid
- pathReady  in  1  consumer accepts pathLoc
- pathLast  out  1  pathLoc is the final (topmost) entry
- replayDone  out  1  one-cycle pulse after last entry accepted
- errOvf  out  1  sticky: push while full
- errUnf  out  1  sticky: pop while empty
- errProto  out  1  sticky: push/pop during replay

## Operation
- States: IDLE, REPLAY, FINISH. Reset -> IDLE.
- IDLE, push only: if !full, mem[sp] <= locIn, sp <= sp+1; else ignored, errOvf <= 1.
- IDLE, pop only: if !empStck, sp <= sp-1; else ignored, errUnf <= 1.
- IDLE, push and pop together: replace top (mem[sp-1] <= locIn, sp unchanged); if empty, behaves as push.
- topLoc = mem[sp-1] when sp>0, else 0 (combinational from sp). empStck = (sp==0); full = (sp==DEPTH).
- IDLE, done=1 and sp==0: go FINISH (empty replay, no pathValid).
- IDLE, done=1 and sp>0: idx <= 0, pathLoc <= mem[0], pathValid <= 1, pathLast <= (sp==1), go REPLAY. done has priority; push/pop in the same cycle are ignored and set errProto.
- REPLAY: handshake = pathValid & pathReady. On handshake, non-last: idx <= idx+1, pathLoc <= mem[idx+1], pathLast <= (idx+2==sp), pathValid stays 1. On handshake with pathLast: pathValid <= 0, pathLast <= 0, go FINISH. No handshake: pathLoc/pathValid/pathLast held stable.
- REPLAY: push/pop ignored and errProto <= 1; done ignored.
- FINISH (one cycle): replayDone = 1, sp <= 0, go IDLE.
- Error flags sticky until reset.

## Timing
- Reset (rst=0, asynchronous): sp=0, state IDLE, idx=0; pathLoc=0, pathValid=0, pathLast=0, replayDone=0, all err flags 0; topLoc=0, empStck=1, full=0. mem contents not reset. Reset mid-replay aborts without replayDone.
- Push/pop take effect at the sampling edge; topLoc/empStck/full reflect it immediately after.
- done sampled at edge N -> pathValid=1 with mem[0] after edge N.
- Throughput one entry per cycle with pathReady held high: K entries accepted at edges N+1..N+K; replayDone high during cycle after edge N+K, IDLE and empStck=1 after edge N+K+1.
- Empty replay: done at edge N -> replayDone high after edge N for one cycle.
- pathValid never deasserts without a handshake (no retraction).

## Test plan
- Reset then push 0x00, 0x01, 0x11 -> topLoc=0x11, empStck=0; pop -> topLoc=0x01; pop twice -> empStck=1, topLoc=0, errUnf=0; third pop -> errUnf=1.
- Push 0x00, 0x10, 0x20, 0x21, pulse done, pathReady=1 -> pathLoc 0x00, 0x10, 0x20, 0x21 on four consecutive cycles, pathLast only with 0x21, one replayDone pulse, then empStck=1.
- Same path with pathReady toggled 1,0,0,1,0,1,1 -> each location held stable while stalled, order unchanged, exactly four handshakes.
- Fill DEPTH entries -> full=1; extra push -> errOvf=1, sp unchanged; simultaneous push 0xAB+pop on top -> topLoc=0xAB, depth unchanged.
- done with empty stack -> replayDone one cycle later, pathValid never asserted; push during REPLAY -> errProto=1, replayed data unaffected.
- Assert rst=0 mid-replay (after 2 of 4 accepted) -> pathValid=0, empStck=1 immediately, no replayDone.

Source files
------------

// File: rtl/path_stack_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : path_stack_reader_if
// Description : Bundle between the maze-solver controller (master) and the
//               location stack / path replayer (slave).
//               master drives push/pop/locIn/done/pathReady.
//               slave drives the stack status, the path stream and the
//               sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
interface path_stack_reader_if #(
    parameter int LOC_W = 8
);
    // stack side
    logic             push;
    logic             pop;
    logic [LOC_W-1:0] locIn;
    logic [LOC_W-1:0] topLoc;
    logic             empStck;
    logic             full;
    // replay side
    logic             done;
    logic [LOC_W-1:0] pathLoc;
    logic             pathValid;
    logic             pathReady;
    logic             pathLast;
    logic             replayDone;
    // sticky error flags
    logic             errOvf;
    logic             errUnf;
    logic             errProto;

    modport master (
        output push, pop, locIn, done, pathReady,
        input  topLoc, empStck, full, pathLoc, pathValid, pathLast,
               replayDone, errOvf, errUnf, errProto
    );

    modport slave (
        input  push, pop, locIn, done, pathReady,
        output topLoc, empStck, full, pathLoc, pathValid, pathLast,
               replayDone, errOvf, errUnf, errProto
    );
endinterface
`default_nettype wire

// File: rtl/path_stack_reader.sv
`default_nettype none
// ============================================================================
// Module      : path_stack_reader
// Description : Location stack fed by the maze-solver controller. Stores
//               pushed cell locations, drops them on pop, and on `done`
//               replays the stored path bottom-to-top over a valid/ready
//               stream, then clears itself.
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous active-low reset
//               bus  - path_stack_reader_if.slave (push/pop/locIn/topLoc/
//                      empStck/full, done/pathLoc/pathValid/pathReady/
//                      pathLast/replayDone, errOvf/errUnf/errProto)
// Revision    : 1.0 - initial release
// ============================================================================
module path_stack_reader #(
    parameter int LOC_W = 8,
    parameter int DEPTH = 256,
    parameter int PTR_W = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    path_stack_reader_if.slave       bus
);

    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REPLAY = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam logic [PTR_W-1:0]  c_SP_ZERO  = '0;
    localparam logic [PTR_W-1:0]  c_SP_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0]  c_SP_DEPTH = PTR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] c_ADDR_ONE = ADDR_W'(1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [PTR_W-1:0]  r_sp;
    logic [PTR_W-1:0]  r_idx;
    logic [LOC_W-1:0]  r_path_loc;
    logic              r_path_valid;
    logic              r_path_last;
    logic              r_err_ovf;
    logic              r_err_unf;
    logic              r_err_proto;
    logic [LOC_W-1:0]  r_mem [DEPTH];

    logic              w_empty;
    logic              w_full;
    logic [ADDR_W-1:0] w_top_addr;
    logic [LOC_W-1:0]  w_top_loc;
    logic              w_idle_op;
    logic              w_hs;
    logic [PTR_W-1:0]  w_idx_next;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic              w_replay_done;

    assign w_empty    = (r_sp == c_SP_ZERO);
    assign w_full     = (r_sp == c_SP_DEPTH);
    // When sp == DEPTH the low bits wrap to 0, so sp-1 still lands on DEPTH-1.
    assign w_top_addr = r_sp[ADDR_W-1:0] - c_ADDR_ONE;
    assign w_top_loc  = w_empty ? '0 : r_mem[w_top_addr];
    // Stack operations only act in IDLE and only when done is not pending.
    assign w_idle_op  = (r_state == S_IDLE) && !bus.done;
    assign w_hs       = r_path_valid && bus.pathReady;
    assign w_idx_next = r_idx + c_SP_ONE;

    // Write port: push+pop on a non-empty stack overwrites the top entry,
    // otherwise a push (or push+pop on empty) appends at sp.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = r_sp[ADDR_W-1:0];
        if (w_idle_op && bus.push) begin
            if (bus.pop && !w_empty) begin
                w_wr_en   = 1'b1;
                w_wr_addr = w_top_addr;
            end else if (!w_full) begin
                w_wr_en   = 1'b1;
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= bus.locIn;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.done) begin
                    w_state_next = w_empty ? S_FINISH : S_REPLAY;
                end
            end
            S_REPLAY: begin
                if (w_hs && r_path_last) begin
                    w_state_next = S_FINISH;
                end
            end
            S_FINISH: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ---------------- FSM: output logic ----------------
    always_comb begin
        w_replay_done = (r_state == S_FINISH);
    end

    // ---------------- Datapath: pointer, replay stream, error flags --------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sp         <= c_SP_ZERO;
            r_idx        <= c_SP_ZERO;
            r_path_loc   <= '0;
            r_path_valid <= 1'b0;
            r_path_last  <= 1'b0;
            r_err_ovf    <= 1'b0;
            r_err_unf    <= 1'b0;
            r_err_proto  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.done) begin
                        // done wins over any stack operation in the same cycle
                        if (bus.push || bus.pop) begin
                            r_err_proto <= 1'b1;
                        end
                        if (!w_empty) begin
                            r_idx        <= c_SP_ZERO;
                            r_path_loc   <= r_mem[{ADDR_W{1'b0}}];
                            r_path_valid <= 1'b1;
                            r_path_last  <= (r_sp == c_SP_ONE);
                        end
                    end else if (bus.push && bus.pop) begin
                        // replace-top keeps depth; on empty it is a plain push
                        if (w_empty) begin
                            r_sp <= r_sp + c_SP_ONE;
                        end
                    end else if (bus.push) begin
                        if (!w_full) begin
                            r_sp <= r_sp + c_SP_ONE;
                        end else begin
                            r_err_ovf <= 1'b1;
                        end
                    end else if (bus.pop) begin
                        if (!w_empty) begin
                            r_sp <= r_sp - c_SP_ONE;
                        end else begin
                            r_err_unf <= 1'b1;
                        end
                    end
                end
                S_REPLAY: begin
                    if (bus.push || bus.pop) begin
                        r_err_proto <= 1'b1;
                    end
                    if (w_hs) begin
                        if (r_path_last) begin
                            r_path_valid <= 1'b0;
                            r_path_last  <= 1'b0;
                        end else begin
                            r_idx       <= w_idx_next;
                            r_path_loc  <= r_mem[w_idx_next[ADDR_W-1:0]];
                            r_path_last <= ((w_idx_next + c_SP_ONE) == r_sp);
                        end
                    end
                end
                S_FINISH: begin
                    r_sp <= c_SP_ZERO;
                end
                default: begin
                    r_sp <= c_SP_ZERO;
                end
            endcase
        end
    end

    assign bus.topLoc     = w_top_loc;
    assign bus.empStck    = w_empty;
    assign bus.full       = w_full;
    assign bus.pathLoc    = r_path_loc;
    assign bus.pathValid  = r_path_valid;
    assign bus.pathLast   = r_path_last;
    assign bus.replayDone = w_replay_done;
    assign bus.errOvf     = r_err_ovf;
    assign bus.errUnf     = r_err_unf;
    assign bus.errProto   = r_err_proto;

endmodule
`default_nettype wire
